// File: rtl/enc_event_fifo.sv
// Event queue behind the 8-to-3 priority encoder: turns each new active code into an
// event, buffers events in a small FIFO drained over valid/ready, and shows the head on a 7-seg digit.
module enc_event_fifo #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  input  logic          tag_in,
  input  logic [2:0]    code_in,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [2:0]    ev_code,
  output logic [CW-1:0] level,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [7:0]    seg_out
);

  localparam int PW = $clog2(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] level_q;
  logic          ovf_q;
  logic          hist_valid;
  logic [2:0]    hist_code;

  logic act, evt, full, empty, pop, push, drop;

  function automatic logic [7:0] seg_decode(input logic [2:0] c);
    logic [7:0] s;
    case (c)
      3'd0:    s = 8'hC0;
      3'd1:    s = 8'hF9;
      3'd2:    s = 8'hA4;
      3'd3:    s = 8'hB0;
      3'd4:    s = 8'h99;
      3'd5:    s = 8'h92;
      3'd6:    s = 8'h82;
      default: s = 8'hF8;
    endcase
    return s;
  endfunction

  // A held code yields one event; a code change or a gap in activity re-arms detection
  assign act   = en_in & tag_in;
  assign evt   = act & (~hist_valid | (code_in != hist_code));
  assign full  = (level_q == CW'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = ~empty & ev_ready;
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      hist_valid <= 1'b0;
      hist_code  <= 3'b000;
    end else begin
      hist_valid <= act;
      if (act) hist_code <= code_in;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + CW'(1);
        2'b01:   level_q <= level_q - CW'(1);
        default: level_q <= level_q;
      endcase
      // A drop in the same cycle as a clear keeps the flag set
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_in;
  end

  assign ev_valid = ~empty;
  assign ev_code  = empty ? 3'b000 : mem[rd_ptr];
  assign seg_out  = empty ? 8'hFF : seg_decode(ev_code);
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_enc_event_fifo.sv
// Directed bench for enc_event_fifo: stimulus queues expected events, a negedge monitor
// checks every accepted pop against that queue; state checks cover level/overflow/reset.
module tb_enc_event_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst, en_in, tag_in, ev_ready, clr_ovf;
  logic [2:0]    code_in;
  logic          ev_valid, overflow;
  logic [2:0]    ev_code;
  logic [CW-1:0] level;
  logic [7:0]    seg_out;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] exp_q [$];
  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  enc_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .tag_in(tag_in), .code_in(code_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .level(level),
    .overflow(overflow), .clr_ovf(clr_ovf), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge state and ready are coherent
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst === 1'b0 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got code %0h expected no pop", ev_code);
      end else begin
        e = exp_q.pop_front();
        check("pop_code", 32'(ev_code), 32'(e));
        check("pop_seg", 32'(seg_out), 32'(seg_tab[e]));
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic tg, input logic [2:0] c,
                      input logic rdy, input logic clr, input int push);
    logic [2:0] pc;
    rst = r; en_in = en; tag_in = tg; code_in = c; ev_ready = rdy; clr_ovf = clr;
    if (r) exp_q.delete();
    if (push >= 0) begin
      pc = push[2:0];
      exp_q.push_back(pc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en_in = 1'b1; tag_in = 1'b1; code_in = 3'd5; ev_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with tag active
    step(1, 1, 1, 3'd5, 0, 0, -1);
    step(1, 1, 1, 3'd5, 0, 0, -1);
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_seg", 32'(seg_out), 32'hFF);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_code", 32'(ev_code), 0);

    // Hold code 5 for 10 cycles -> one event
    step(0, 1, 1, 3'd5, 0, 0, 5);
    check("latency_level", 32'(level), 1);
    repeat (9) step(0, 1, 1, 3'd5, 0, 0, -1);
    check("hold_level", 32'(level), 1);
    check("hold_code", 32'(ev_code), 5);
    check("hold_seg", 32'(seg_out), 32'h92);
    check("hold_valid", 32'(ev_valid), 1);
    step(0, 0, 1, 3'd2, 0, 0, -1);
    check("en_low_level", 32'(level), 1);
    step(0, 0, 0, 3'd0, 1, 0, -1);
    check("drain_level", 32'(level), 0);
    check("drain_valid", 32'(ev_valid), 0);
    check("drain_seg", 32'(seg_out), 32'hFF);

    // 1,1,3,gap,3,7 -> queue 1,3,3,7
    step(0, 1, 1, 3'd1, 0, 0, 1);
    step(0, 1, 1, 3'd1, 0, 0, -1);
    step(0, 1, 1, 3'd3, 0, 0, 3);
    step(0, 0, 0, 3'd3, 0, 0, -1);
    step(0, 1, 1, 3'd3, 0, 0, 3);
    step(0, 1, 1, 3'd7, 0, 0, 7);
    check("fill_level", 32'(level), 4);
    check("fill_head", 32'(ev_code), 1);
    check("fill_ovf", 32'(overflow), 0);

    // Full: drop without pop, accept with coincident pop
    step(0, 1, 1, 3'd2, 0, 0, -1);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_level", 32'(level), 4);
    check("drop_head", 32'(ev_code), 1);
    step(0, 0, 0, 3'd2, 0, 0, -1);
    step(0, 1, 1, 3'd2, 1, 0, 2);
    check("fullpop_level", 32'(level), 4);
    check("fullpop_ovf", 32'(overflow), 1);
    check("fullpop_head", 32'(ev_code), 3);

    // Drop wins over clear; clear alone then takes effect
    step(0, 1, 1, 3'd4, 0, 1, -1);
    check("setwins_ovf", 32'(overflow), 1);
    check("setwins_level", 32'(level), 4);
    step(0, 0, 0, 3'd4, 0, 1, -1);
    check("clr_ovf", 32'(overflow), 0);

    step(0, 0, 0, 3'd0, 1, 0, -1);
    check("pop3_level", 32'(level), 3);
    check("pop3_head", 32'(ev_code), 3);

    // Reset mid-stream with event and pop pending
    step(1, 1, 1, 3'd6, 1, 0, -1);
    check("midrst_level", 32'(level), 0);
    check("midrst_valid", 32'(ev_valid), 0);
    check("midrst_ovf", 32'(overflow), 0);
    check("midrst_seg", 32'(seg_out), 32'hFF);
    step(0, 1, 1, 3'd6, 0, 0, 6);
    repeat (3) step(0, 1, 1, 3'd6, 0, 0, -1);
    check("rearm_level", 32'(level), 1);
    check("rearm_code", 32'(ev_code), 6);
    check("rearm_seg", 32'(seg_out), 32'h82);
    step(0, 0, 0, 3'd0, 1, 0, -1);
    check("final_level", 32'(level), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
